// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter: operand handshake in,
// one-hot tagged results out.
interface mult_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [N-1:0]      resp_data;
  logic              busy;

  modport master (
    output req_valid, req_lock, req_a, req_b,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_lock, req_a, req_b,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding one registered signed fixed-point multiplier;
// results return to the originating requester two cycles after the grant.
module mult_arbiter #(
  parameter int N    = 32,
  parameter int FRAC = 20,
  parameter int NREQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  mult_arbiter_if.slave  bus
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [TW-1:0]       last;
  logic [TW-1:0]       next_last;
  logic [TW-1:0]       grant_idx;
  logic                grant_any;
  logic                xfer;
  logic [N-1:0]        grant_a;
  logic [N-1:0]        grant_b;
  logic [N-1:0]        a_arr [NREQ];
  logic [N-1:0]        b_arr [NREQ];

  logic                s1_valid;
  logic [TW-1:0]       s1_tag;
  logic [N-1:0]        s1_a;
  logic [N-1:0]        s1_b;
  logic                s2_valid;
  logic [TW-1:0]       s2_tag;
  logic [N-1:0]        res_q;
  logic signed [2*N-1:0] product;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[gi*N +: N];
    assign b_arr[gi] = bus.req_b[gi*N +: N];
  end

  // Search starts just after the last grant and wraps around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!grant_any && bus.req_valid[TW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = TW'(idx);
      end
    end
  end

  assign xfer    = grant_any && !rst;
  assign grant_a = a_arr[grant_idx];
  assign grant_b = b_arr[grant_idx];

  assign bus.req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

  // A locked grant parks the pointer one behind the winner so it stays first.
  always_comb begin
    next_last = last;
    if (xfer) begin
      if (bus.req_lock[grant_idx]) begin
        next_last = (grant_idx == '0) ? TW'(NREQ-1) : grant_idx - TW'(1);
      end else begin
        next_last = grant_idx;
      end
    end
  end

  assign product = $signed({{N{s1_a[N-1]}}, s1_a}) * $signed({{N{s1_b[N-1]}}, s1_b});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= TW'(NREQ-1);
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      res_q    <= '0;
    end else begin
      last     <= next_last;
      s1_valid <= xfer;
      if (xfer) begin
        s1_a   <= grant_a;
        s1_b   <= grant_b;
        s1_tag <= grant_idx;
      end
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      // Arithmetic shift then truncate: drops fraction bits toward -inf, wraps on overflow.
      if (s1_valid) begin
        res_q <= N'(product >>> FRAC);
      end
    end
  end

  assign bus.resp_valid = s2_valid ? (NREQ'(1) << s2_tag) : '0;
  assign bus.resp_data  = res_q;
  assign bus.busy       = s1_valid | s2_valid;
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized and directed bench for mult_arbiter against a queue-based
// reference of round-robin grants and fixed-point products.
module tb_mult_arbiter;
  localparam int N    = 32;
  localparam int FRAC = 20;
  localparam int NREQ = 4;

  typedef struct {
    int          due;
    logic [3:0]  onehot;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] v  = '0;
  logic [NREQ-1:0] lk = '0;
  logic [N-1:0]    a [NREQ];
  logic [N-1:0]    b [NREQ];
  logic [NREQ*N-1:0] pa, pb;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int m_last     = NREQ-1;
  int last_grant = -1;
  logic [31:0] last_data = '0;
  exp_t q[$];
  int grant_log[$];

  mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  mult_arbiter #(.N(N), .FRAC(FRAC), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    pa = '0;
    pb = '0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i*N +: N] = a[i];
      pb[i*N +: N] = b[i];
    end
  end

  assign bus.req_valid = v;
  assign bus.req_lock  = lk;
  assign bus.req_a     = pa;
  assign bus.req_b     = pb;

  function automatic logic [31:0] ref_mul(logic [31:0] x, logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p >>> FRAC;
    return p[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_last    = NREQ-1;
    last_data = '0;
  endtask

  // One clock of reference checking: grant, response and busy at the negedge,
  // model update at the posedge, return 1 ns later for new stimulus.
  task automatic tick();
    int g;
    logic [3:0] exp_ready, exp_rv;
    logic [31:0] exp_data;
    logic exp_busy;
    exp_t e;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
    vectors++;
    if (bus.req_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL grant cyc=%0d: got %b expected %b", cyc, bus.req_ready, exp_ready);
    end
    exp_busy = (q.size() != 0);
    exp_rv   = 4'b0000;
    exp_data = last_data;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_rv    = e.onehot;
      exp_data  = e.data;
      last_data = e.data;
    end
    vectors++;
    if (bus.resp_valid !== exp_rv || bus.resp_data !== exp_data) begin
      miscompares++;
      $display("FAIL resp cyc=%0d: got %b/%h expected %b/%h", cyc,
               bus.resp_valid, bus.resp_data, exp_rv, exp_data);
    end
    vectors++;
    if (bus.busy !== exp_busy) begin
      miscompares++;
      $display("FAIL busy cyc=%0d: got %b expected %b", cyc, bus.busy, exp_busy);
    end
    @(posedge clk);
    cyc++;
    last_grant = g;
    if (g >= 0) begin
      e.due    = cyc + 1;
      e.onehot = 4'(1 << g);
      e.data   = ref_mul(a[g], b[g]);
      q.push_back(e);
      m_last = lk[g] ? (g + NREQ - 1) % NREQ : g;
      grant_log.push_back(g);
    end
    #1;
  endtask

  task automatic apply_reset(int ncyc);
    rst = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      v  = NREQ'($urandom);
      lk = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        a[i] = $urandom;
        b[i] = $urandom;
      end
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 4'b0 || bus.resp_valid !== 4'b0 ||
          bus.resp_data !== 32'h0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got ready=%b rv=%b data=%h busy=%b expected all zero",
                 bus.req_ready, bus.resp_valid, bus.resp_data, bus.busy);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    v   = '0;
    lk  = '0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(3);
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic single_op(int r, logic [31:0] x, logic [31:0] y, logic [31:0] want, string name);
    logic [3:0] oh;
    oh = 4'(1 << r);
    v = '0; v[r] = 1'b1;
    a[r] = x; b[r] = y;
    tick();
    v = '0;
    vectors++;
    if (bus.resp_valid !== 4'b0) begin
      miscompares++;
      $display("FAIL %s_early: got %b expected 0000", name, bus.resp_valid);
    end
    tick();
    vectors++;
    if (bus.resp_valid !== oh || bus.resp_data !== want) begin
      miscompares++;
      $display("FAIL %s: got %b/%h expected %b/%h", name, bus.resp_valid, bus.resp_data, oh, want);
    end
    tick();
    tick();
  endtask

  task automatic test_single_arith();
    single_op(2, 32'h00100000, 32'h00100000, 32'h00100000, "mul_1x1");
    single_op(2, 32'h00180000, 32'h00200000, 32'h00300000, "mul_1p5x2");
    single_op(2, 32'hFFF00000, 32'h00200000, 32'hFFE00000, "mul_m1x2");
  endtask

  task automatic test_overflow();
    single_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFF000, "wrap_max");
    single_op(1, 32'h80000000, 32'h80000000, 32'h00000000, "wrap_min");
  endtask

  task automatic test_round_robin();
    int base;
    apply_reset(1);
    base = grant_log.size();
    v = 4'b1111; lk = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = $urandom; b[i] = $urandom; end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (last_grant >= 0) begin a[last_grant] = $urandom; b[last_grant] = $urandom; end
    end
    v = '0;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (grant_log.size() <= base + c || grant_log[base + c] != c % NREQ) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", c,
                 (grant_log.size() > base + c) ? grant_log[base + c] : -1, c % NREQ);
      end
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_lock();
    int base, n1;
    int want[7] = '{1, 1, 1, 1, 3, 1, 3};
    apply_reset(1);
    base = grant_log.size();
    n1 = 0;
    v = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      lk = '0;
      lk[1] = (n1 < 3);
      tick();
      if (last_grant == 1) n1++;
      if (last_grant >= 0) begin a[last_grant] = $urandom; b[last_grant] = $urandom; end
    end
    v = '0; lk = '0;
    for (int c = 0; c < 7; c++) begin
      vectors++;
      if (grant_log.size() <= base + c || grant_log[base + c] != want[c]) begin
        miscompares++;
        $display("FAIL lock_seq[%0d]: got %0d expected %0d", c,
                 (grant_log.size() > base + c) ? grant_log[base + c] : -1, want[c]);
      end
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_back_to_back();
    int base;
    base = grant_log.size();
    v = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      lk = NREQ'($urandom);
      a[0] = pick_operand(); b[0] = pick_operand();
      tick();
    end
    v = '0;
    vectors++;
    if (grant_log.size() != base + 6) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected 6", grant_log.size() - base);
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < NREQ; i++) begin a[i] = pick_operand(); b[i] = pick_operand(); end
    for (int c = 0; c < 400; c++) begin
      lk = NREQ'($urandom);
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || last_grant == i) begin
          v[i] = ($urandom_range(0, 2) != 0);
          a[i] = pick_operand();
          b[i] = pick_operand();
        end
      end
    end
    v = '0;
    for (int c = 0; c < 4; c++) tick();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic test_midflight_reset();
    v = 4'b0011;
    a[0] = $urandom; b[0] = $urandom;
    a[1] = $urandom; b[1] = $urandom;
    tick();
    v = 4'b0010;
    tick();
    rst = 1'b1;
    v = '0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.resp_valid !== 4'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_drop: got rv=%b busy=%b expected 0000/0", bus.resp_valid, bus.busy);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = 4'b1000;
    a[3] = 32'h00300000; b[3] = 32'hFFE00000;
    tick();
    v = '0;
    tick();
    vectors++;
    if (bus.resp_valid !== 4'b1000 || bus.resp_data !== 32'hFFA00000) begin
      miscompares++;
      $display("FAIL midreset_after: got %b/%h expected 1000/ffa00000", bus.resp_valid, bus.resp_data);
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = '0; end
    test_reset();
    test_single_arith();
    test_overflow();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_random();
    test_midflight_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
